// File: rtl/gray_bin_conv_seq.sv
// gray_bin_conv_seq: bit-serial Gray<->binary converter, STEP bits/cycle MSB first (in_valid/in_ready/in_mode/din in, out_valid/out_ready/dout/out_mode out, busy while converting)
module gray_bin_conv_seq #(
  parameter int N = 10,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [N-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] dout,
  output logic         out_mode,
  output logic         busy
);
  localparam int C = (N + STEP - 1) / STEP;
  localparam int W = C * STEP;
  localparam int CW = C > 1 ? $clog2(C) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q;
  logic [W-1:0] data_q, res_q, res_d;
  logic [STEP-1:0] chunk_d;
  logic [CW-1:0] cnt_q;
  logic [N-1:0] dout_q;
  logic mode_q, carry_q, carry_d, out_mode_q, acc;
  always_comb begin
    carry_d = carry_q;
    chunk_d = '0;
    for (int j = 0; j < STEP; j++) begin
      chunk_d[STEP-1-j] = carry_d ^ data_q[W-1-j];
      carry_d = mode_q ? data_q[W-1-j] : chunk_d[STEP-1-j];
    end
    res_d = (res_q << STEP) | W'(chunk_d);
  end
  assign in_ready = state_q == IDLE || (state_q == DONE && out_ready);
  assign acc = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign busy = state_q == BUSY;
  assign dout = dout_q;
  assign out_mode = out_mode_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      mode_q <= 1'b0;
      carry_q <= 1'b0;
      dout_q <= '0;
      out_mode_q <= 1'b0;
    end else if (acc) begin
      state_q <= BUSY;
      data_q <= W'(din) << (W - N);
      res_q <= '0;
      cnt_q <= '0;
      mode_q <= in_mode;
      carry_q <= 1'b0;
    end else if (state_q == BUSY) begin
      data_q <= data_q << STEP;
      res_q <= res_d;
      carry_q <= carry_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(C - 1)) begin
        state_q <= DONE;
        dout_q <= res_d[W-1 -: N];
        out_mode_q <= mode_q;
      end
    end else if (state_q == DONE && out_ready) begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_gray_bin_conv_seq.sv
// tb_gray_bin_conv_seq: directed vectors, back-pressure, mid-conversion reset and full sweeps for STEP in {1,2,3,5,10}
module tb_gray_bin_conv_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  typedef struct {
    logic       m;
    logic [9:0] din;
    logic [9:0] exp;
  } vec_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [9:0] b2g(input logic [9:0] x);
    return x ^ (x >> 1);
  endfunction
  function automatic logic [9:0] g2b(input logic [9:0] x);
    logic [9:0] r;
    r[9] = x[9];
    for (int i = 8; i >= 0; i--) r[i] = r[i+1] ^ x[i];
    return r;
  endfunction
  for (genvar g = 0; g < 5; g++) begin : u
    localparam int S = g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 3 : g == 3 ? 5 : 10;
    localparam int C = (10 + S - 1) / S;
    logic rst_n, iv, ir, im, ov, ordy, om, bsy;
    logic [9:0] din, dout;
    gray_bin_conv_seq #(.N(10), .STEP(S)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_mode(im), .din(din),
      .out_valid(ov), .out_ready(ordy), .dout(dout), .out_mode(om), .busy(bsy)
    );
    task automatic send(input logic m, input logic [9:0] w, input logic hs, output logic [9:0] r, output logic ro, output int lat);
      @(negedge clk);
      iv = 1'b1;
      im = m;
      din = w;
      ordy = 1'b0;
      @(negedge clk);
      iv = 1'b0;
      lat = 0;
      while (!ov && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      r = dout;
      ro = om;
      if (hs) begin
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
      end
    endtask
    task automatic xact(input string nm, input logic m, input logic [9:0] w, input logic [9:0] exp, output logic [9:0] r);
      logic ro;
      int lat;
      send(m, w, 1'b1, r, ro, lat);
      chk($sformatf("s%0d_%s_dout", S, nm), r, exp);
      chk($sformatf("s%0d_%s_lat", S, nm), lat, C);
      chk($sformatf("s%0d_%s_mode", S, nm), ro, m);
    endtask
    initial begin
      vec_t v[8];
      logic [9:0] r, gr, br, held;
      logic ro;
      int lat, seen, rc;
      v[0] = '{1'b0, 10'b0100100100, 10'b0111000111};
      v[1] = '{1'b0, 10'b1000001001, 10'b1111110001};
      v[2] = '{1'b1, 10'b0111000111, 10'b0100100100};
      v[3] = '{1'b1, 10'b1111100011, 10'b1000010010};
      v[4] = '{1'b0, 10'b0000000000, 10'b0000000000};
      v[5] = '{1'b1, 10'b1111111111, 10'b1000000000};
      v[6] = '{1'b0, 10'b1111111111, 10'b1010101010};
      v[7] = '{1'b1, 10'b0000000001, 10'b0000000001};
      rst_n = 1'b0;
      iv = 1'b0;
      im = 1'b0;
      din = '0;
      ordy = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk($sformatf("s%0d_rst_in_ready", S), ir, 1);
      chk($sformatf("s%0d_rst_out_valid", S), ov, 0);
      chk($sformatf("s%0d_rst_dout", S), dout, 0);
      chk($sformatf("s%0d_rst_busy", S), bsy, 0);
      chk($sformatf("s%0d_rst_out_mode", S), om, 0);
      for (int i = 0; i < 8; i++) xact($sformatf("vec%0d", i), v[i].m, v[i].din, v[i].exp, r);
      send(1'b1, 10'b1111100011, 1'b0, held, ro, lat);
      chk($sformatf("s%0d_bp_first", S), held, 10'b1000010010);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk($sformatf("s%0d_bp_dout_%0d", S, i), dout, held);
        chk($sformatf("s%0d_bp_in_ready_%0d", S, i), ir, 0);
        chk($sformatf("s%0d_bp_out_valid_%0d", S, i), ov, 1);
      end
      iv = 1'b1;
      im = 1'b0;
      din = 10'b1100000001;
      ordy = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      ordy = 1'b0;
      chk($sformatf("s%0d_b2b_busy", S), bsy, 1);
      chk($sformatf("s%0d_b2b_out_valid", S), ov, 0);
      lat = 0;
      while (!ov && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("s%0d_b2b_lat", S), lat, C);
      chk($sformatf("s%0d_b2b_dout", S), dout, 10'b1000000001);
      chk($sformatf("s%0d_b2b_mode", S), om, 0);
      ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;
      @(negedge clk);
      iv = 1'b1;
      im = 1'b0;
      din = 10'b0100100100;
      @(negedge clk);
      iv = 1'b0;
      rc = C < 3 ? C : 3;
      repeat (rc - 1) @(negedge clk);
      chk($sformatf("s%0d_mid_busy_before", S), bsy, 1);
      rst_n = 1'b0;
      #1;
      chk($sformatf("s%0d_mid_in_ready", S), ir, 1);
      chk($sformatf("s%0d_mid_out_valid", S), ov, 0);
      chk($sformatf("s%0d_mid_dout", S), dout, 0);
      chk($sformatf("s%0d_mid_busy", S), bsy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (C + 3) begin
        @(negedge clk);
        if (ov) seen++;
      end
      chk($sformatf("s%0d_mid_stale_valid", S), seen, 0);
      xact("fresh", 1'b1, 10'b1111100011, 10'b1000010010, r);
      for (int w = 0; w < 1024; w++) begin
        xact($sformatf("b2g_%0d", w), 1'b1, 10'(w), b2g(10'(w)), gr);
        xact($sformatf("g2b_%0d", w), 1'b0, gr, g2b(gr), br);
        chk($sformatf("s%0d_rt_%0d", S, w), br, w);
      end
      done_cnt++;
    end
  end
  initial begin
    for (int i = 0; i < 60000 && done_cnt < 5; i++) @(negedge clk);
    if (done_cnt < 5) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: %0d of 5 instances finished, required 5", done_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
